// File: rtl/axis_switch_pkg.sv
// Shared helpers for the packet-aware AXI-Stream crossbar: dest window decode and
// round-robin pick.
package axis_switch_pkg;

  localparam int unsigned MaxPorts = 32;
  localparam int unsigned IdxW     = $clog2(MaxPorts);

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } rr_pick_t;

  // True when dest falls inside master idx's window [lo, lo + rng].
  function automatic logic dest_match(input logic [31:0] dest, input int unsigned idx,
                                      input int unsigned base, input int unsigned stride,
                                      input int unsigned rng);
    logic [63:0] lo;
    lo = 64'(base) + 64'(idx) * 64'(stride);
    return (64'(dest) >= lo) && (64'(dest) <= lo + 64'(rng));
  endfunction

  // First set bit of req scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MaxPorts-1:0] req, input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < MaxPorts; k++) begin
      pos = ptr + k;
      if (pos >= n) pos = pos - n;
      if (k < n && !res.found && req[pos[IdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[IdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_switch_rrobin_pkt_if.sv
// Bundle of N AXI-Stream lanes, flattened per field; master drives payload, slave drives ready.
interface axis_switch_rrobin_pkt_if #(
  parameter int unsigned N          = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1
);
  logic [N-1:0]            valid;
  logic [N-1:0]            ready;
  logic [N*DATA_WIDTH-1:0] data;
  logic [N*DEST_WIDTH-1:0] dest;
  logic [N*ID_WIDTH-1:0]   id;
  logic [N-1:0]            last;

  modport master (output valid, data, dest, id, last, input ready);
  modport slave  (input valid, data, dest, id, last, output ready);
endinterface

// File: rtl/axis_switch_master_arb.sv
// Per-master round-robin arbiter with packet lock, feeding a 2-entry registered skid FIFO.
module axis_switch_master_arb
  import axis_switch_pkg::*;
#(
  parameter int unsigned NSLAVES    = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter bit          HAS_LAST   = 1'b1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NSLAVES-1:0]            req,
  input  logic [NSLAVES*DATA_WIDTH-1:0] s_data,
  input  logic [NSLAVES*DEST_WIDTH-1:0] s_dest,
  input  logic [NSLAVES*ID_WIDTH-1:0]   s_id,
  input  logic [NSLAVES-1:0]            s_last,
  output logic [NSLAVES-1:0]            slv_ready,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [DEST_WIDTH-1:0]         m_dest,
  output logic [ID_WIDTH-1:0]           m_id,
  output logic                          m_last
);

  localparam int unsigned SlvW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
  } entry_t;

  logic [SlvW-1:0] rr_ptr_q, rr_ptr_d, lock_slv_q, lock_slv_d, gnt_idx;
  logic            locked_q, locked_d;
  entry_t          head_q, head_d, tail_q, tail_d, push_entry;
  logic [1:0]      count_q, count_d;
  logic            gnt_any, full, push, pop;
  rr_pick_t        pick;

  always_comb begin
    pick = rr_pick(MaxPorts'(req), 32'(rr_ptr_q), NSLAVES);
    // A locked master only ever serves its packet owner, even if it goes idle.
    if (locked_q) begin
      gnt_idx = lock_slv_q;
      gnt_any = req[lock_slv_q];
    end else begin
      gnt_idx = SlvW'(pick.idx);
      gnt_any = pick.found;
    end
    full = (count_q == 2'd2);
    push = aresetn && gnt_any && !full;
    pop  = (count_q != 2'd0) && m_ready;

    slv_ready = '0;
    if (push) slv_ready[gnt_idx] = 1'b1;

    push_entry.data = s_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    push_entry.dest = s_dest[gnt_idx*DEST_WIDTH +: DEST_WIDTH];
    push_entry.id   = s_id[gnt_idx*ID_WIDTH +: ID_WIDTH];
    push_entry.last = s_last[gnt_idx];
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_slv_d = lock_slv_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (push) begin
      rr_ptr_d = (gnt_idx == SlvW'(NSLAVES - 1)) ? '0 : gnt_idx + 1'b1;
      if (HAS_LAST && !push_entry.last) begin
        locked_d   = 1'b1;
        lock_slv_d = gnt_idx;
      end else begin
        locked_d = 1'b0;
      end
    end

    // Push at count 2 cannot happen since ready is low when full.
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_entry;
        else                 tail_d = push_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_entry;
        end else begin
          head_d = tail_q;
          tail_d = push_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_slv_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_slv_q <= lock_slv_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign m_valid = aresetn && (count_q != 2'd0);
  assign m_data  = head_q.data;
  assign m_dest  = head_q.dest;
  assign m_id    = head_q.id;
  assign m_last  = head_q.last;

endmodule

// File: rtl/axis_switch_rrobin_pkt.sv
// NSLAVES x NMASTERS packet-aware AXI-Stream crossbar: dest routing, per-master arbiters,
// and a saturating counter of discarded unroutable beats.
module axis_switch_rrobin_pkt
  import axis_switch_pkg::*;
#(
  parameter int unsigned NSLAVES       = 2,
  parameter int unsigned NMASTERS      = 2,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ID_WIDTH      = 1,
  parameter int unsigned DEST_WIDTH    = 1,
  parameter bit          HAS_LAST      = 1'b1,
  parameter int unsigned DEST_BASE     = 0,
  parameter int unsigned DEST_STRIDE   = 1,
  parameter int unsigned DEST_RANGE    = 0,
  parameter bit          DROP_UNROUTED = 1'b1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_switch_rrobin_pkt_if.slave   s,
  axis_switch_rrobin_pkt_if.master  m,
  output logic [CNT_WIDTH-1:0]      drop_cnt
);

  localparam int unsigned SumW  = $clog2(NSLAVES + 1);
  localparam int unsigned WideW = CNT_WIDTH + SumW;

  logic [NSLAVES-1:0]    hit, drop_ok;
  logic [NSLAVES-1:0]    req       [NMASTERS];
  logic [NSLAVES-1:0]    arb_ready [NMASTERS];
  logic [NMASTERS-1:0]   m_valid_w, m_last_w;
  logic [DATA_WIDTH-1:0] m_data_w  [NMASTERS];
  logic [DEST_WIDTH-1:0] m_dest_w  [NMASTERS];
  logic [ID_WIDTH-1:0]   m_id_w    [NMASTERS];
  logic [SumW-1:0]       n_drop;
  logic [WideW-1:0]      drop_wide;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  // Each slave requests only the lowest-indexed master whose window holds its dest.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NMASTERS; i++) req[i] = '0;
    for (int unsigned j = 0; j < NSLAVES; j++) begin
      for (int unsigned i = 0; i < NMASTERS; i++) begin
        if (!hit[j] && (NMASTERS == 1 ||
            dest_match(32'(s.dest[j*DEST_WIDTH +: DEST_WIDTH]), i, DEST_BASE, DEST_STRIDE,
                       DEST_RANGE))) begin
          hit[j]    = 1'b1;
          req[i][j] = s.valid[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NMASTERS; i++) begin : g_master
    axis_switch_master_arb #(
      .NSLAVES    (NSLAVES),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .DEST_WIDTH (DEST_WIDTH),
      .HAS_LAST   (HAS_LAST)
    ) u_arb (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .req       (req[i]),
      .s_data    (s.data),
      .s_dest    (s.dest),
      .s_id      (s.id),
      .s_last    (s.last),
      .slv_ready (arb_ready[i]),
      .m_valid   (m_valid_w[i]),
      .m_ready   (m.ready[i]),
      .m_data    (m_data_w[i]),
      .m_dest    (m_dest_w[i]),
      .m_id      (m_id_w[i]),
      .m_last    (m_last_w[i])
    );
  end

  always_comb begin
    m.valid = m_valid_w;
    m.last  = m_last_w;
    m.data  = '0;
    m.dest  = '0;
    m.id    = '0;
    for (int unsigned i = 0; i < NMASTERS; i++) begin
      m.data[i*DATA_WIDTH +: DATA_WIDTH] = m_data_w[i];
      m.dest[i*DEST_WIDTH +: DEST_WIDTH] = m_dest_w[i];
      m.id[i*ID_WIDTH +: ID_WIDTH]       = m_id_w[i];
    end
  end

  always_comb begin
    drop_ok = '0;
    n_drop  = '0;
    s.ready = '0;
    for (int unsigned j = 0; j < NSLAVES; j++) begin
      if (DROP_UNROUTED && s.valid[j] && !hit[j]) begin
        drop_ok[j] = 1'b1;
        n_drop     = n_drop + 1'b1;
      end
      s.ready[j] = drop_ok[j];
      for (int unsigned i = 0; i < NMASTERS; i++) s.ready[j] = s.ready[j] | arb_ready[i][j];
      s.ready[j] = s.ready[j] & aresetn;
    end
    drop_wide  = WideW'(drop_cnt_q) + WideW'(n_drop);
    drop_cnt_d = (drop_wide > WideW'({CNT_WIDTH{1'b1}})) ? '1 : drop_wide[CNT_WIDTH-1:0];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/axis_switch_rrobin_pkt.md
Name: axis_switch_rrobin_pkt

Overview:
- Parametrised NSLAVES x NMASTERS AXI-Stream crossbar with per-master round-robin arbitration.
- Packet-aware: a grant is held from the first beat to the beat with last.
- Each master output has a 2-entry registered skid FIFO for full throughput and registered outputs.
- Beats with an unroutable dest are either dropped and counted, or stall the slave.
- Sits between accelerator stream ports and the manager's command/completion queues.

Parameters:
- NSLAVES, 2, number of slave (input) ports, >=1
- NMASTERS, 2, number of master (output) ports, >=1
- DATA_WIDTH, 64, tdata width per port
- ID_WIDTH, 1, tid width per port
- DEST_WIDTH, 1, tdest width per port
- HAS_LAST, 1, 1 = hold grant until last; 0 = re-arbitrate every beat
- DEST_BASE, 0, dest value routed to master 0
- DEST_STRIDE, 1, dest increment between consecutive masters
- DEST_RANGE, 0, master i accepts dest in [DEST_BASE+i*DEST_STRIDE, DEST_BASE+i*DEST_STRIDE+DEST_RANGE]
- DROP_UNROUTED, 1, 1 = accept and discard unroutable beats; 0 = never ready for them
- CNT_WIDTH, 16, width of the drop counter

Ports:
- aclk, in, 1, clock
- aresetn, in, 1, synchronous active-low reset
- s_valid, in, NSLAVES, slave tvalid
- s_ready, out, NSLAVES, slave tready
- s_data, in, NSLAVES*DATA_WIDTH, slave tdata, slot j at [j*DATA_WIDTH +: DATA_WIDTH]
- s_dest, in, NSLAVES*DEST_WIDTH, slave tdest
- s_id, in, NSLAVES*ID_WIDTH, slave tid
- s_last, in, NSLAVES, slave tlast
- m_valid, out, NMASTERS, master tvalid
- m_ready, in, NMASTERS, master tready
- m_data, out, NMASTERS*DATA_WIDTH, master tdata
- m_dest, out, NMASTERS*DEST_WIDTH, master tdest, passed through unchanged
- m_id, out, NMASTERS*ID_WIDTH, master tid
- m_last, out, NMASTERS, master tlast
- drop_cnt, out, CNT_WIDTH, count of dropped beats, saturating

Behaviour:
- Reset: sync on aclk when aresetn=0. Clears FIFOs, locks and drop_cnt; rr_ptr=0. m_valid=0 and s_ready=0 while in reset. m_data/m_dest/m_id/m_last are don't-care while m_valid=0.
- Routing:
  - Slave j requests master i when s_valid[j] and its dest lies in master i's window.
  - With NMASTERS=1, every valid beat requests master 0.
  - Overlapping windows: the lowest i wins.
- Arbiter state per master: rr_ptr (0..NSLAVES-1), locked, lock_slv.
  - IDLE (locked=0): grant the first requesting slave scanning rr_ptr, rr_ptr+1, ... mod NSLAVES.
  - LOCKED: grant = lock_slv, regardless of other requests.
- s_ready[j] = granted by its routed master AND that master's FIFO not full (count<2). Ready may depend on s_valid; the other AXI-S rules hold.
- On handshake for master i from slave j:
  - push {data, dest, id, last} into the FIFO;
  - rr_ptr <= (j+1) mod NSLAVES;
  - if HAS_LAST and !s_last: locked <= 1, lock_slv <= j;
  - if s_last or !HAS_LAST: locked <= 0.
- While LOCKED, if lock_slv stays idle or changes dest, the master waits. No timeout, no re-arbitration.
- FIFO: 2 entries, registered outputs.
  - m_valid = count != 0.
  - Simultaneous push and pop at count=2 is not allowed, because ready is already low.
  - At count=1, push and pop in the same cycle keeps count=1.
  - Latency s handshake -> m_valid is 1 cycle. Sustained throughput is 1 beat/cycle per master with m_ready held high.
- Unroutable beat (no window matches):
  - DROP_UNROUTED=1: s_ready[j]=1, beat discarded, drop_cnt += 1, saturating at all-ones.
  - DROP_UNROUTED=0: s_ready[j]=0 permanently.
- Distinct masters serve distinct slaves concurrently. One slave drives at most one master per cycle.
- Reset mid-packet: lock released, buffered beats lost, the next packet is arbitrated from rr_ptr=0.

Decomposition:
- Package axis_switch_pkg:
  - function dest_match(dest, i), built from DEST_BASE/STRIDE/RANGE;
  - function rr_pick(req, ptr) returning the index and a found flag;
  - typedef for the FIFO entry struct (parametrised widths, via macro or per-instance localparam).
- Sub-module axis_switch_master_arb: one per master. Holds rr_ptr/lock, grant logic and the 2-entry skid FIFO.
- Top level: routing decode, s_ready OR-reduction across masters, drop counter.

Test Plan (NSLAVES=3, NMASTERS=2, DEST_BASE=0, DEST_STRIDE=1, DEST_RANGE=0, HAS_LAST=1):
- Fairness: all 3 slaves send single-beat packets (last=1) to dest 0, m_ready=1 -> m_data order is slave 0,1,2,0,1,2, one beat per cycle after 1-cycle latency.
- Packet lock: slave 1 sends 4 beats (last on beat 4) while slave 0 and slave 2 are also requesting dest 0 -> the 4 beats appear contiguously on master 0; slave 2 is granted next.
- Parallel routing: slave 0 streams to dest 0 and slave 2 to dest 1, both 8 beats -> both masters show 8 beats in the same cycles with no interleaving.
- Backpressure: m_ready[0]=0 for 5 cycles during a stream -> exactly 2 beats buffered, s_ready low, no loss or duplication after release.
- Drop: slave 1 sends dest=1 with DEST_WIDTH=2 and dest=3 -> dest=3 beats are accepted, drop_cnt goes 0->1->2, nothing appears on any m_valid.
- Reset: aresetn=0 for 1 cycle after beat 2 of a 4-beat packet -> m_valid=0 next cycle, lock cleared; a new packet from slave 2 is granted immediately.
